// File: rtl/apb_rw_scheduler.sv
// Shares one APB master port between a read and a write request stream:
// round-robin arbitration, SETUP/ACCESS sequencing, PREADY timeout, one response per request.
module apb_rw_scheduler #(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_req_valid,
  output logic                    wr_req_ready,
  input  logic [ADDR_WIDTH-1:0]   wr_req_addr,
  input  logic [DATA_WIDTH-1:0]   wr_req_data,
  input  logic [DATA_WIDTH/8-1:0] wr_req_strb,
  output logic                    wr_rsp_valid,
  input  logic                    wr_rsp_ready,
  output logic                    wr_rsp_err,
  input  logic                    rd_req_valid,
  output logic                    rd_req_ready,
  input  logic [ADDR_WIDTH-1:0]   rd_req_addr,
  output logic                    rd_rsp_valid,
  input  logic                    rd_rsp_ready,
  output logic [DATA_WIDTH-1:0]   rd_rsp_data,
  output logic                    rd_rsp_err,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int unsigned CNT_WIDTH = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  typedef enum logic {GRANT_WRITE, GRANT_READ} grant_t;

  state_t               state, state_nxt;
  grant_t               last_grant;
  logic                 is_write;
  logic                 err_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [CNT_WIDTH-1:0] tmo_cnt;
  logic                 pick_rd, pick_wr;
  logic                 timeout_hit;
  logic                 rsp_ready;

  // Read wins unless a write is also pending and the read was served last.
  assign pick_rd     = rd_req_valid && (!wr_req_valid || last_grant == GRANT_WRITE);
  assign pick_wr     = wr_req_valid && !pick_rd;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == CNT_WIDTH'(TIMEOUT_CYCLES));
  assign rsp_ready   = is_write ? wr_rsp_ready : rd_rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pick_rd || pick_wr) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (pready || timeout_hit) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    psel         = (state == SETUP) || (state == ACCESS);
    penable      = (state == ACCESS);
    wr_rsp_valid = (state == RESP) && is_write;
    rd_rsp_valid = (state == RESP) && !is_write;
    wr_req_ready = 1'b0;
    rd_req_ready = 1'b0;
    if (state == IDLE && !rst) begin
      wr_req_ready = pick_wr;
      rd_req_ready = pick_rd;
    end
  end

  assign rd_rsp_data = rd_data_q;
  assign wr_rsp_err  = err_q && is_write;
  assign rd_rsp_err  = err_q && !is_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GRANT_WRITE;
      is_write   <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      pstrb      <= '0;
      pwrite     <= 1'b0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_rd || pick_wr) begin
            is_write   <= pick_wr;
            pwrite     <= pick_wr;
            last_grant <= pick_wr ? GRANT_WRITE : GRANT_READ;
            paddr      <= pick_wr ? wr_req_addr : rd_req_addr;
            pwdata     <= pick_wr ? wr_req_data : '0;
            pstrb      <= pick_wr ? wr_req_strb : '0;
          end
        end
        SETUP: tmo_cnt <= '0;
        ACCESS: begin
          if (pready) begin
            err_q <= pslverr;
            if (!is_write) rd_data_q <= prdata;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
            if (!is_write) rd_data_q <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
